// File: rtl/sp_ram_bank_arb.sv
// Two-port, word-interleaved, multi-bank single-port RAM with per-bank round-robin
// arbitration and a req/gnt/rvalid response pipeline of depth 1+OUT_REG.

module sp_ram_bank #(
  parameter int DW = 32,
  parameter int RW = 11
) (
  input  logic            clk,
  input  logic            en,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [RW-1:0]   row,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);
  localparam int DEPTH = 1 << RW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DW/8; i++)
          if (be[i]) mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
      end else begin
        rdata <= mem[row];
      end
    end
  end
endmodule

module sp_ram_bank_arb #(
  parameter int RAM_SIZE   = 32768,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int OUT_REG    = 0,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                             clk,
  input  logic                             rstn_i,
  input  logic [1:0]                       req_i,
  input  logic [1:0][ADDR_WIDTH-1:0]       addr_i,
  input  logic [1:0]                       we_i,
  input  logic [1:0][DATA_WIDTH/8-1:0]     be_i,
  input  logic [1:0][DATA_WIDTH-1:0]       wdata_i,
  output logic [1:0]                       gnt_o,
  output logic [1:0]                       rvalid_o,
  output logic [1:0][DATA_WIDTH-1:0]       rdata_o
);
  localparam int NBE    = DATA_WIDTH / 8;
  localparam int OFS    = $clog2(NBE);
  localparam int BB     = $clog2(NUM_BANKS);
  localparam int RW     = ADDR_WIDTH - OFS - BB;
  localparam int STAGES = 1 + OUT_REG;

  logic [1:0][BB-1:0]                  bank_sel;
  logic [1:0][RW-1:0]                  row_sel;
  logic [NUM_BANKS-1:0]                hit0, hit1, win0, win1, prio;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rd;

  logic [1:0][STAGES-1:0]              vld_pipe;
  logic [1:0]                          rd_q;
  logic [1:0][BB-1:0]                  bank_q;
  logic [1:0][DATA_WIDTH-1:0]          rdata_q, rd_live;

  for (genvar p = 0; p < 2; p++) begin : g_dec
    assign bank_sel[p] = addr_i[p][OFS +: BB];
    assign row_sel[p]  = addr_i[p][ADDR_WIDTH-1:OFS+BB];
  end

  if (OFS > 0) begin : g_unused
    logic unused_ofs;
    assign unused_ofs = ^{addr_i[0][OFS-1:0], addr_i[1][OFS-1:0]};
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign hit0[b] = req_i[0] && (bank_sel[0] == BB'(b));
    assign hit1[b] = req_i[1] && (bank_sel[1] == BB'(b));
    // prio[b] names the port that wins when both hit this bank
    assign win0[b] = hit0[b] && (!hit1[b] || !prio[b]);
    assign win1[b] = hit1[b] && (!hit0[b] ||  prio[b]);

    sp_ram_bank #(.DW(DATA_WIDTH), .RW(RW)) u_bank (
      .clk   (clk),
      .en    ((win0[b] | win1[b]) & rstn_i),
      .we    (win1[b] ? we_i[1]    : we_i[0]),
      .be    (win1[b] ? be_i[1]    : be_i[0]),
      .row   (win1[b] ? row_sel[1] : row_sel[0]),
      .wdata (win1[b] ? wdata_i[1] : wdata_i[0]),
      .rdata (bank_rd[b])
    );
  end

  assign gnt_o = {|win1, |win0};

  // Contested banks hand priority to the loser; uncontested ones keep it.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) prio <= '0;
    else         prio <= prio ^ (hit0 & hit1);
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      vld_pipe <= '0;
      rd_q     <= '0;
      bank_q   <= '0;
      rdata_q  <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_pipe[p] <= (vld_pipe[p] << 1) | STAGES'(gnt_o[p]);
        rd_q[p]     <= gnt_o[p] & ~we_i[p];
        bank_q[p]   <= bank_sel[p];
        if (vld_pipe[p][0] && rd_q[p]) rdata_q[p] <= rd_live[p];
      end
    end
  end

  // Without the output stage, read data bypasses rdata_q during rvalid so
  // rdata_q only serves as the hold value between responses.
  always_comb begin
    rd_live  = '0;
    rdata_o  = '0;
    rvalid_o = '0;
    for (int p = 0; p < 2; p++) begin
      rd_live[p]  = bank_rd[bank_q[p]];
      rvalid_o[p] = vld_pipe[p][STAGES-1];
      rdata_o[p]  = (OUT_REG == 0 && vld_pipe[p][0] && rd_q[p]) ? rd_live[p] : rdata_q[p];
    end
  end
endmodule

// File: tb/tb_sp_ram_bank_arb.sv
// Scoreboard bench: two instances (OUT_REG=0 and OUT_REG=1) share the same stimulus;
// the driver queues expected responses, a negedge monitor pops and compares them.

module tb_sp_ram_bank_arb;
  logic              clk = 0;
  logic              rstn = 0;
  logic [1:0]        req = '0, we = '0;
  logic [1:0][14:0]  addr = '0;
  logic [1:0][3:0]   be = '0;
  logic [1:0][31:0]  wdata = '0;
  logic [1:0]        gnt0, gnt1, rv0, rv1;
  logic [1:0][31:0]  rd0, rd1;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    int          dut;
    int          port;
    int          due;
    bit          rd;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_ram_bank_arb #(.OUT_REG(0)) u_dut0 (
    .clk(clk), .rstn_i(rstn), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt0), .rvalid_o(rv0), .rdata_o(rd0));

  sp_ram_bank_arb #(.OUT_REG(1)) u_dut1 (
    .clk(clk), .rstn_i(rstn), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the oldest queued entry for that dut/port.
  logic        mv;
  logic [31:0] mr;
  int          mi;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        mv = d ? rv1[p] : rv0[p];
        mr = d ? rd1[p] : rd0[p];
        if (mv) begin
          mi = -1;
          foreach (sb[i]) if (mi < 0 && sb[i].dut == d && sb[i].port == p) mi = i;
          checks++;
          if (mi < 0) begin
            errors++;
            $display("FAIL unexpected_rvalid dut%0d port%0d: got rvalid=1 expected 0 (cycle %0d)", d, p, cyc);
          end else begin
            if (cyc != sb[mi].due) begin
              errors++;
              $display("FAIL rvalid_latency dut%0d port%0d: got cycle %0d expected %0d", d, p, cyc, sb[mi].due);
            end
            if (sb[mi].rd) begin
              checks++;
              if (mr !== sb[mi].data) begin
                errors++;
                $display("FAIL rdata dut%0d port%0d: got %h expected %h (cycle %0d)", d, p, mr, sb[mi].data, cyc);
              end
            end
            sb.delete(mi);
          end
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due < cyc) begin
        errors++;
        $display("FAIL missing_rvalid dut%0d port%0d: got none expected at cycle %0d", sb[i].dut, sb[i].port, sb[i].due);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int d, input int p, input int due, input bit rd, input logic [31:0] data);
    exp_t e;
    e.dut = d; e.port = p; e.due = due; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // One request cycle: drive both ports, check gnt, queue expected responses.
  task automatic drv(input logic [1:0] rq, input logic [1:0] w,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [3:0] b0, input logic [3:0] b1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] eg, input logic [31:0] e0, input logic [31:0] e1);
    @(negedge clk);
    req = rq; we = w;
    addr[0] = a0[14:0]; addr[1] = a1[14:0];
    be[0] = b0; be[1] = b1;
    wdata[0] = d0; wdata[1] = d1;
    #1;
    chk("gnt_dut0", 64'(gnt0), 64'(eg));
    chk("gnt_dut1", 64'(gnt1), 64'(eg));
    for (int p = 0; p < 2; p++) begin
      if (eg[p]) begin
        push(0, p, cyc + 1, !w[p], p ? e1 : e0);
        push(1, p, cyc + 2, !w[p], p ? e1 : e0);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req = '0; we = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rvalid_dut0", 64'(rv0), 64'd0);
    chk("reset_rvalid_dut1", 64'(rv1), 64'd0);
    chk("reset_rdata_dut0", 64'(rd0), 64'd0);
    chk("reset_rdata_dut1", 64'(rd1), 64'd0);
    rstn = 1;
    idle(1);

    // single write then read on port 1, read-after-write
    drv(2'b10, 2'b10, 0, 16'h0010, 0, 4'hF, 0, 32'hDEADBEEF, 2'b10, 0, 0);
    drv(2'b10, 2'b00, 0, 16'h0010, 0, 0, 0, 0, 2'b10, 0, 32'hDEADBEEF);
    idle(2);

    // byte-enable merge
    drv(2'b10, 2'b10, 0, 16'h0020, 0, 4'hF, 0, 32'h11223344, 2'b10, 0, 0);
    drv(2'b10, 2'b10, 0, 16'h0020, 0, 4'h5, 0, 32'hAABBCCDD, 2'b10, 0, 0);
    drv(2'b10, 2'b00, 0, 16'h0020, 0, 0, 0, 0, 2'b10, 0, 32'h11BB33DD);
    idle(2);

    // different banks: concurrent writes then concurrent reads
    drv(2'b11, 2'b11, 16'h0000, 16'h0004, 4'hF, 4'hF, 32'hA0A0A0A0, 32'hB1B1B1B1, 2'b11, 0, 0);
    drv(2'b11, 2'b00, 16'h0000, 16'h0004, 0, 0, 0, 0, 2'b11, 32'hA0A0A0A0, 32'hB1B1B1B1);
    idle(3);
    chk("hold_rdata_dut0_p0", 64'(rd0[0]), 64'hA0A0A0A0);
    chk("hold_rdata_dut0_p1", 64'(rd0[1]), 64'hB1B1B1B1);
    chk("hold_rdata_dut1_p0", 64'(rd1[0]), 64'hA0A0A0A0);
    chk("hold_rdata_dut1_p1", 64'(rd1[1]), 64'hB1B1B1B1);

    // bank 2 contention: grants alternate starting with port 0
    drv(2'b01, 2'b01, 16'h0008, 0, 4'hF, 0, 32'h08080808, 0, 2'b01, 0, 0);
    drv(2'b10, 2'b10, 0, 16'h0018, 0, 4'hF, 0, 32'h18181818, 2'b10, 0, 0);
    drv(2'b11, 2'b00, 16'h0008, 16'h0018, 0, 0, 0, 0, 2'b01, 32'h08080808, 32'h18181818);
    drv(2'b11, 2'b00, 16'h0008, 16'h0018, 0, 0, 0, 0, 2'b10, 32'h08080808, 32'h18181818);
    drv(2'b11, 2'b00, 16'h0008, 16'h0018, 0, 0, 0, 0, 2'b01, 32'h08080808, 32'h18181818);
    drv(2'b11, 2'b00, 16'h0008, 16'h0018, 0, 0, 0, 0, 2'b10, 32'h08080808, 32'h18181818);
    idle(3);

    // streaming: 8 writes then 8 back-to-back reads on port 0
    for (int i = 0; i < 8; i++)
      drv(2'b01, 2'b01, 16'(i*4), 0, 4'hF, 0, 32'hC0DE0000 | 32'(i*4), 0, 2'b01, 0, 0);
    for (int i = 0; i < 8; i++)
      drv(2'b01, 2'b00, 16'(i*4), 0, 0, 0, 0, 0, 2'b01, 32'hC0DE0000 | 32'(i*4), 0);
    idle(3);

    // set up bank 3 priority = port 1, and a known word at 0x0030
    drv(2'b10, 2'b10, 0, 16'h0030, 0, 4'hF, 0, 32'h55555555, 2'b10, 0, 0);
    drv(2'b11, 2'b00, 16'h000C, 16'h001C, 0, 0, 0, 0, 2'b01, 32'hC0DE000C, 0);
    drv(2'b10, 2'b00, 16'h000C, 16'h001C, 0, 0, 0, 0, 2'b10, 0, 32'hC0DE001C);
    idle(3);

    // reset between grant and rvalid: response must be dropped
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr[0] = 15'h0000;
    #1;
    chk("inflight_gnt_dut0", 64'(gnt0), 64'h1);
    @(posedge clk);
    #1 rstn = 0;
    #1;
    chk("rst_rvalid_dut0", 64'(rv0), 64'd0);
    chk("rst_rvalid_dut1", 64'(rv1), 64'd0);
    chk("rst_rdata_dut0", 64'(rd0), 64'd0);
    chk("rst_rdata_dut1", 64'(rd1), 64'd0);
    @(negedge clk);
    req = 2'b10; we = 2'b10; addr[1] = 15'h0030; be[1] = 4'hF; wdata[1] = 32'hBAD0BAD0;
    #1;
    chk("rst_gnt_dut0", 64'(gnt0), 64'h2);
    chk("rst_gnt_dut1", 64'(gnt1), 64'h2);
    repeat (2) @(negedge clk);
    req = '0; we = '0;
    rstn = 1;
    repeat (4) @(negedge clk);

    // priority back to port 0 on bank 3; suppressed write left 0x0030 intact
    drv(2'b11, 2'b00, 16'h000C, 16'h001C, 0, 0, 0, 0, 2'b01, 32'hC0DE000C, 0);
    drv(2'b10, 2'b00, 16'h000C, 16'h001C, 0, 0, 0, 0, 2'b10, 0, 32'hC0DE001C);
    drv(2'b01, 2'b00, 16'h0030, 0, 0, 0, 0, 0, 2'b01, 32'h55555555, 0);
    idle(5);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sp_ram_bank_arb.md
Name: sp_ram_bank_arb

Overview:
- Dual-requestor, word-interleaved, multi-bank single-port RAM with per-bank round-robin arbitration and a PULP-style req/gnt/rvalid protocol.
- Successor to the single-port RAM wrapper: generalised in data width, bank count and read latency.
- Lets the core instruction port (port 0) and data port (port 1) reach one shared memory, with concurrent access whenever they target different banks.

Parameters:
- RAM_SIZE, 32768, total capacity in bytes; power of 2.
- DATA_WIDTH, 32, word width in bits; power of 2, >= 8.
- NUM_BANKS, 4, number of interleaved banks; power of 2, >= 2.
- OUT_REG, 0, 1 adds an output register stage (read latency 2 instead of 1).
- ADDR_WIDTH, $clog2(RAM_SIZE), byte-address width.

Ports:
- clk  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- req_i  in  2  access request per port, bit p = port p
- addr_i  in  2*ADDR_WIDTH  byte address per port
- we_i  in  2  1 = write, 0 = read, per port
- be_i  in  2*DATA_WIDTH/8  byte enables per port, 1 = write byte
- wdata_i  in  2*DATA_WIDTH  write data per port
- gnt_o  out  2  grant per port, combinational from req/addr and arbiter state
- rvalid_o  out  2  response valid per port
- rdata_o  out  2*DATA_WIDTH  read data per port

Behaviour:
- Interface: one clock, clk. Reset rstn_i is asynchronous and active-low.
- Address decode:
  - OFS = log2(DATA_WIDTH/8); BB = log2(NUM_BANKS).
  - bank = addr[OFS +: BB]; row = addr[ADDR_WIDTH-1 : OFS+BB].
  - addr[OFS-1:0] is ignored.
- Each bank holds RAM_SIZE/(DATA_WIDTH/8)/NUM_BANKS words. It is a synchronous-read, byte-enable-write array.
- Memory contents are not reset.
- Arbitration, evaluated every cycle:
  - gnt_o[p] = req_i[p] AND (no other request targets the same bank, OR port p holds that bank's priority).
  - Each bank has a 1-bit priority pointer, reset to 0 (port 0 wins).
  - On a contested grant, that bank's pointer flips to the loser on the next clk edge. Uncontested grants leave the pointer unchanged.
  - Both ports to different banks: both granted in the same cycle.
- Access on grant:
  - Granted write updates the bytes with be=1 at the clk edge. Bytes with be=0 are preserved.
  - Granted read samples the row at the clk edge.
  - Ungranted requests have no side effect; the requester holds its request until granted.
- Response:
  - rvalid_o[p] pulses once per grant, for reads and writes: cycle T+1 if OUT_REG=0, T+2 if OUT_REG=1, where T is the grant cycle.
  - For reads, rdata_o[p] is valid while rvalid_o[p]=1. For writes, rdata_o is don't-care.
  - Outside rvalid, rdata_o[p] holds its last value.
  - Back-to-back grants produce back-to-back rvalids. Full throughput is 1 access per port per cycle.
- Response routing: the bank index and rvalid are tracked per port in a pipeline register of depth 1+OUT_REG. Responses are never reordered.
- Hazards:
  - Read of a row in the cycle after a write to it returns the new data.
  - No simultaneous same-bank read and write occurs, because arbitration serialises them.
- Reset, asynchronous on rstn_i low:
  - rvalid_o = 0, rdata_o = 0, all priority pointers = 0, response pipeline cleared.
  - In-flight responses are dropped.
  - gnt_o still follows req_i combinationally during reset.
  - Writes are suppressed while rstn_i = 0.
- Synthesis: for DATA_WIDTH=32, NUM_BANKS=4, each bank maps to one macro. Technology macro selection is not part of this block.

Test Plan:
- Single write then read, port 1, OUT_REG=0: write addr 0x0010, data 0xDEADBEEF, be 0xF; read 0x0010 -> gnt same cycle, rvalid at T+1, rdata 0xDEADBEEF.
- Byte-enable merge: write 0x11223344 to 0x0020, then write 0xAABBCCDD with be 0x5 -> read returns 0x11BB33DD.
- No conflict: port 0 reads 0x0000 (bank 0) while port 1 reads 0x0004 (bank 1) in the same cycle -> both gnt=1, both rvalid next cycle, with correct data.
- Conflict fairness: both ports request bank 2 (0x0008 and 0x0018) continuously for 4 cycles -> grants alternate P0, P1, P0, P1, each stalled port sees gnt=0, and rvalid count per port = 2.
- OUT_REG=1 streaming: port 0 issues 8 consecutive reads 0x0000..0x001C -> rvalid from T+2 for 8 consecutive cycles, data in order.
- Reset mid-operation: assert rstn_i low between grant and rvalid -> rvalid_o and rdata_o go to 0 immediately, no late rvalid after release, and priority pointers return to port 0.
